regfile_writer: RTL
===================

Name: regfile_writer

Overview:
- Write side of the 32x32 register file; the counterpart of the 32:1 read-select mux tree.
- Accepts write requests over a valid/ready handshake and stages each one for a cycle.
- Decodes the 5-bit address into a one-hot write enable and updates the storage array.
- Exposes all 32 registers as a packed bus for the read muxes, and supports a sequential clear sweep.

Parameters:
- WIDTH, 32, data width of each register
- NREGS, 32, number of registers; the address is log2(NREGS) = 5 bits
- ZERO_REG, 31, register index that is hardwired to zero

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous, active-low reset
- wr_valid  input  1  write request present
- wr_ready  output  1  writer can accept a request this cycle
- wr_addr  input  5  destination register index
- wr_data  input  WIDTH  write data
- wr_ack  output  1  one-cycle pulse after a staged write commits
- clr_req  input  1  request to zero the whole file
- clr_done  output  1  one-cycle pulse when the clear sweep finishes
- regs_out  output  [NREGS-1:0][WIDTH-1:0]  packed register contents, feeds the read muxes

Behaviour:
- Reset: one clock only. Reset is sampled at the posedge while reset_n=0.
  - All registers go to 0; the stage is emptied; state=IDLE; the sweep counter goes to 0.
  - wr_ack=0 and clr_done=0.
  - Reset asserted mid-sweep or mid-write aborts that operation; nothing is acked.
- States: IDLE, CLEAR.
- IDLE:
  - wr_ready = ~clr_req (combinational).
  - A request is accepted at edge N when wr_valid & wr_ready; addr and data are latched into the stage (stage_v=1).
- Commit:
  - At edge N+1, decoder5_32 drives a one-hot enable from the stage address, gated by stage_v.
  - regs[addr] <= data at that edge; the new value is visible on regs_out after N+1.
  - wr_ack=1 for the cycle after N+1.
- Throughput: one write per cycle. Back-to-back accepts while staged writes commit are legal; there are no bubbles.
- Same address on consecutive cycles: the later write wins, with the commit order equal to the accept order.
- ZERO_REG:
  - A write to 31 is accepted and acked, but the enable is suppressed.
  - regs_out[31] is constant 0 in all states.
- IDLE to CLEAR: on clr_req=1 at the edge.
  - No request is accepted that cycle.
  - A write already staged still commits at this edge and is acked normally.
- CLEAR:
  - wr_ready=0.
  - The counter idx runs 0..NREGS-2; regs[idx] <= 0 each cycle, one register per cycle, 31 cycles.
  - After the idx=30 edge: state goes to IDLE, clr_done=1 for one cycle, counter returns to 0.
- clr_req during CLEAR or on the clr_done cycle is ignored; it is sampled only in IDLE.
- Widths: the address is exactly 5 bits, with no out-of-range handling. The data is stored unmodified.

Decomposition:
- Package regfile_pkg holds:
  - NREGS, WIDTH, ZERO_REG and ADDR_W=5
  - state enum {IDLE, CLEAR}
  - typedef reg_word_t = logic [WIDTH-1:0]
- Sub-module decoder5_32: inputs en and addr[4:0], output a 32-bit one-hot vector. It is the write-side dual of the read mux.
- The storage, stage and FSM live in regfile_writer.

Test Plan:
- Reset then idle: drive reset_n=0 for 2 cycles, then release.
  - Required: every regs_out is 0, wr_ready=1, wr_ack=0, clr_done=0.
- Single write: accept addr=5, data=0xDEADBEEF at edge N.
  - Required: regs_out[5]=0xDEADBEEF after edge N+1; wr_ack high exactly one cycle; every other register is unchanged.
- Back-to-back writes: three consecutive cycles writing (3,0x11), (3,0x22), (7,0x33).
  - Required: three wr_ack pulses.
  - Required: final regs_out[3]=0x22, regs_out[7]=0x33.
  - Required: wr_ready stays 1 throughout.
- Zero register: write addr=31, data=0xFFFFFFFF.
  - Required: wr_ack pulses and regs_out[31] stays 0.
- Clear with a pending write: accept (9,0xAB) at edge N, and assert clr_req in the cycle after N.
  - Required: the write commits and is acked.
  - Required: wr_ready=0 for 31 cycles, clr_done pulses once, and all registers are 0 afterwards.
- Reset mid-clear: drop reset_n at sweep idx=10.
  - Required: all registers 0 and state IDLE on the next cycle.
  - Required: no clr_done pulse.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizes, FSM states and word type for the register file write side
package regfile_pkg;
    localparam int WIDTH = 32;
    localparam int NREGS = 32;
    localparam int ZERO_REG = 31;
    localparam int ADDR_W = 5;
    typedef enum logic {IDLE, CLEAR} state_t;
    typedef logic [WIDTH-1:0] reg_word_t;
endpackage

// File: rtl/regfile_writer_decoder.sv
// decoder5_32: one-hot write enable from a register index, dual of the read mux
module decoder5_32
    import regfile_pkg::*;
(
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    output logic [NREGS-1:0]  onehot
);
    assign onehot = en ? NREGS'(1) << addr : '0;
endmodule

// File: rtl/regfile_writer.sv
// regfile_writer: staged valid/ready write port, storage array and clear sweep
module regfile_writer
    import regfile_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [WIDTH-1:0]             wr_data,
    output logic                         wr_ack,
    input  logic                         clr_req,
    output logic                         clr_done,
    output logic [NREGS-1:0][WIDTH-1:0]  regs_out
);
    state_t                          r_state, w_next;
    logic                            r_stage_v, r_ack, r_clr_done;
    logic [ADDR_W-1:0]               r_stage_addr, r_idx;
    reg_word_t                       r_stage_data;
    logic [NREGS-1:0][WIDTH-1:0]     r_regs;
    logic                            w_last, w_accept, w_commit, w_sweep;
    logic [NREGS-1:0]                w_wen, w_clr;

    always_comb begin
        w_last   = r_idx == ADDR_W'(NREGS - 2);
        wr_ready = r_state == IDLE && !clr_req;
        // clr_req on the clr_done cycle is ignored so one request yields one sweep
        w_next   = r_state == IDLE ? ((clr_req && !r_clr_done) ? CLEAR : IDLE)
                                   : (w_last ? IDLE : CLEAR);
    end

    assign w_accept = wr_valid && wr_ready;
    assign w_commit = r_stage_v && r_stage_addr != ADDR_W'(ZERO_REG);
    assign w_sweep  = r_state == CLEAR;
    assign wr_ack   = r_ack;
    assign clr_done = r_clr_done;

    decoder5_32 u_wr_dec  (.en(w_commit), .addr(r_stage_addr), .onehot(w_wen));
    decoder5_32 u_clr_dec (.en(w_sweep),  .addr(r_idx),        .onehot(w_clr));

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_stage_v    <= 1'b0;
            r_stage_addr <= '0;
            r_stage_data <= '0;
            r_ack        <= 1'b0;
            r_clr_done   <= 1'b0;
            r_idx        <= '0;
        end else begin
            r_stage_v  <= w_accept;
            if (w_accept) begin
                r_stage_addr <= wr_addr;
                r_stage_data <= wr_data;
            end
            r_ack      <= r_stage_v;
            r_clr_done <= w_sweep && w_last;
            r_idx      <= (w_sweep && !w_last) ? r_idx + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) r_regs <= '0;
        else
            for (int i = 0; i < NREGS; i++)
                if (w_clr[i]) r_regs[i] <= '0;
                else if (w_wen[i]) r_regs[i] <= r_stage_data;
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_out
        assign regs_out[g] = r_regs[g] & {WIDTH{g != ZERO_REG}};
    end
endmodule
